// File: rtl/uart_mul.sv
// uart_mul: UART-attached 32x32 multiplier, big-endian operands and result.
// Define UART_MUL_FULL_PRODUCT_EN to return the full 64-bit product.
module uart_mul #(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic uart_rx,
    output logic uart_tx,
    output logic busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
`ifdef UART_MUL_FULL_PRODUCT_EN
    localparam int RW = 64;
    localparam int NBYTES = 8;
`else
    localparam int RW = 32;
    localparam int NBYTES = 4;
`endif
    localparam logic [2:0] LAST = 3'(NBYTES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {ST_COLLECT, ST_MULT, ST_SEND} top_state_e;

    rx_state_e       rx_state_q;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;
    logic            rx_stb_q;

    top_state_e      st_q;
    logic [63:0]     op_q;
    logic [2:0]      byte_cnt_q;
    logic            busy_q;
    logic [RW-1:0]   res_q;
    logic [RW-1:0]   prod;
    logic [7:0]      tx_data_q;
    logic [3:0]      tx_bit_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [2:0]      tx_byte_q;
    logic            tx_q;

`ifdef UART_MUL_FULL_PRODUCT_EN
    assign prod = 64'(op_q[63:32]) * 64'(op_q[31:0]);
`else
    assign prod = op_q[63:32] * op_q[31:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_stb_q   <= 1'b0;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            rx_stb_q  <= 1'b0;
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        // A line already back high here was only a glitch
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == FULL) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == FULL) begin
                        rx_cnt_q   <= '0;
                        rx_stb_q   <= rx_sync_q;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_COLLECT;
            op_q       <= '0;
            byte_cnt_q <= '0;
            busy_q     <= 1'b0;
            res_q      <= '0;
            tx_data_q  <= '0;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
            tx_byte_q  <= '0;
            tx_q       <= 1'b1;
        end else begin
            unique case (st_q)
                ST_COLLECT: begin
                    if (rx_stb_q) begin
                        op_q   <= {op_q[55:0], rx_shift_q};
                        busy_q <= 1'b1;
                        if (byte_cnt_q == 3'd7) begin
                            byte_cnt_q <= '0;
                            st_q       <= ST_MULT;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                end
                ST_MULT: begin
                    // Start bit of the first reply byte goes out right away
                    res_q     <= prod << 8;
                    tx_data_q <= prod[RW-1 -: 8];
                    tx_q      <= 1'b0;
                    tx_bit_q  <= '0;
                    tx_cnt_q  <= '0;
                    tx_byte_q <= '0;
                    st_q      <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_cnt_q != FULL) begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end else begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 4'd9) begin
                            if (tx_byte_q == LAST) begin
                                st_q   <= ST_COLLECT;
                                busy_q <= 1'b0;
                            end else begin
                                tx_byte_q <= tx_byte_q + 1'b1;
                                tx_bit_q  <= '0;
                                tx_q      <= 1'b0;
                                tx_data_q <= res_q[RW-1 -: 8];
                                res_q     <= res_q << 8;
                            end
                        end else begin
                            tx_bit_q <= tx_bit_q + 1'b1;
                            if (tx_bit_q == 4'd8) begin
                                tx_q <= 1'b1;
                            end else begin
                                tx_q      <= tx_data_q[0];
                                tx_data_q <= tx_data_q >> 1;
                            end
                        end
                    end
                end
                default: st_q <= ST_COLLECT;
            endcase
        end
    end

    assign uart_tx = tx_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_uart_mul.sv
// tb_uart_mul: directed bench for uart_mul (reset, multiply, framing, abort).
// Expected bytes follow UART_MUL_FULL_PRODUCT_EN when it is defined.
`timescale 1ns/1ps
module tb_uart_mul;
    localparam int CLK_HZ = 2_304_000;
    localparam int BAUD   = 115_200;
    localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_MUL_FULL_PRODUCT_EN
    localparam int NB = 8;
`else
    localparam int NB = 4;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_rx = 1'b1;
    wire  uart_tx;
    wire  busy;
    int   errors = 0;
    int   checks = 0;

    uart_mul #(
        .CLK_FREQ_HZ(CLK_HZ),
        .BAUD_RATE  (BAUD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ncl(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        ncl(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            ncl(CPB);
        end
        uart_rx = stop;
        ncl(CPB);
        uart_rx = 1'b1;
    endtask

    // Returns at the middle of the received stop bit
    task automatic rx_byte(input int maxwait, output logic [7:0] b);
        int w;
        w = 0;
        b = 'x;
        while (uart_tx !== 1'b0 && w < maxwait) begin
            @(negedge clk);
            w++;
        end
        checks++;
        assert (w < maxwait) else begin
            errors++;
            $error("FAIL tx_start_timeout: waited %0d cycles, limit %0d",
                   w, maxwait);
        end
        if (w < maxwait) begin
            ncl(CPB / 2);
            chk("tx_start_bit", uart_tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
                ncl(CPB);
                b[i] = uart_tx;
            end
            ncl(CPB);
            chk("tx_stop_bit", uart_tx, 1'b1);
        end
    endtask

    task automatic xfer(input string tag, input logic [63:0] ab,
                        input logic [63:0] prod, input bit bad);
        logic [7:0] got;
        fork
            for (int i = 0; i < 8; i++) begin
                send_byte(ab[8*(7-i) +: 8], 1'b1);
                if (bad && i == 2) begin
                    send_byte(8'hA5, 1'b0);
                    ncl(CPB);
                end
            end
            for (int k = 0; k < NB; k++) begin
                rx_byte((k == 0) ? 120 * CPB : CPB / 2 + 3, got);
                chk({tag, "_byte"}, got, prod[8*(NB-1-k) +: 8]);
            end
        join
        ncl(CPB / 2 - 2);
        chk({tag, "_busy_last_stop"}, busy, 1'b1);
        ncl(4);
        chk({tag, "_busy_done"}, busy, 1'b0);
        chk({tag, "_tx_idle"}, uart_tx, 1'b1);
    endtask

    initial begin
        int lows;
        logic [7:0] first;

        rst_n = 1'b0;
        ncl(10);
        chk("rst_tx", uart_tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        lows = 0;
        repeat (20 * CPB) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        chk("rst_quiet_tx", lows, 0);
        chk("rst_quiet_busy", busy, 1'b0);

        xfer("basic", 64'h00000002_00000004, 64'h00000000_00000008, 1'b0);
        xfer("carry", 64'h00012345_00000100, 64'h00000000_01234500, 1'b0);
        xfer("ovf", 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
        xfer("frame", 64'h00001000_00000010, 64'h00000000_00010000, 1'b1);

        lows = 0;
        repeat (12 * CPB) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        chk("frame_single_reply", lows, 0);

        fork
            for (int i = 0; i < 8; i++) begin
                send_byte((i == 3) ? 8'd7 : ((i == 7) ? 8'd9 : 8'd0), 1'b1);
            end
            begin
                rx_byte(120 * CPB, first);
                chk("abort_first_byte", first, 8'h00);
            end
        join
        ncl(CPB / 2 + 3 * CPB);
        chk("abort_busy_pre", busy, 1'b1);
        chk("abort_tx_low_pre", uart_tx, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", uart_tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        ncl(5);
        rst_n = 1'b1;
        ncl(5);

        xfer("fresh", 64'h00000003_00000005, 64'h00000000_0000000F, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
